// File: rtl/alu_seg_display_pkg.sv
// Shared constants for the ALU result display: digit count, blank codes and the
// active-low hex-to-7-segment table ({g,f,e,d,c,b,a}).
package alu_seg_display_pkg;

  localparam int          NUM_DIGITS = 8;
  localparam int          IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam logic [7:0]  ANS_OFF    = 8'hFF;

  // Entry 0 is the rightmost element.
  localparam logic [15:0][6:0] HEX7 = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/alu_seg_display_hex_to_seg7.sv
// Combinational nibble to active-low 7-segment pattern.
module hex_to_seg7
  import alu_seg_display_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX7[nib_i];
  end

endmodule

// File: rtl/alu_seg_display.sv
// Captures the ALU result/overflow on load and scans it in hex across an
// 8-digit multiplexed 7-segment display, one digit per SCAN_DIV clocks.
module alu_seg_display
  import alu_seg_display_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] y_i,
  input  logic        overflow_i,
  output logic [7:0]  ans_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        ovf_led_o
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0]    div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      val_q, val_d;
  logic             ovf_q, ovf_d;
  logic             tick;
  logic [31:0]      shifted;
  logic             blank;
  logic [6:0]       hex_seg;
  logic [7:0]       ans_d;
  logic [6:0]       seg_d;
  logic             dp_d;

  hex_to_seg7 u_hex (
    .nib_i (shifted[3:0]),
    .seg_o (hex_seg)
  );

  always_comb begin
    tick  = (div_q == DW'(SCAN_DIV - 1));
    div_d = tick ? '0 : div_q + DW'(1);
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    val_d = load_i ? y_i : val_q;
    ovf_d = load_i ? overflow_i : ovf_q;

    // Current digit sits in the low nibble; everything above it zero means a leading zero.
    shifted = val_q >> {idx_q, 2'b00};
    blank   = BLANK_LZ && (idx_q != '0) && (shifted == '0);
    ans_d   = blank ? ANS_OFF : ~(8'b1 << idx_q);
    seg_d   = blank ? SEG_BLANK : hex_seg;
    dp_d    = ~((idx_q == '0) && ovf_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q     <= '0;
      idx_q     <= '0;
      val_q     <= '0;
      ovf_q     <= 1'b0;
      ans_o     <= ANS_OFF;
      seg_o     <= SEG_BLANK;
      dp_o      <= 1'b1;
      ovf_led_o <= 1'b0;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      val_q     <= val_d;
      ovf_q     <= ovf_d;
      ans_o     <= ans_d;
      seg_o     <= seg_d;
      dp_o      <= dp_d;
      ovf_led_o <= ovf_q;
    end
  end

endmodule

// File: tb/tb_alu_seg_display.sv
// Scoreboard bench: a cycle-count reference model pushes expected outputs at each
// edge; a negedge monitor pops and compares for two instances (BLANK_LZ 1 and 0).
module tb_alu_seg_display;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1, load = 1'b0, ovf = 1'b0;
  logic [31:0] y = '0;
  logic [7:0]  ans0, ans1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1, led0, led1;

  always #5 clk = ~clk;

  alu_seg_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut0 (
    .clk_i(clk), .rst_i(rst), .load_i(load), .y_i(y), .overflow_i(ovf),
    .ans_o(ans0), .seg_o(seg0), .dp_o(dp0), .ovf_led_o(led0));

  alu_seg_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst), .load_i(load), .y_i(y), .overflow_i(ovf),
    .ans_o(ans1), .seg_o(seg1), .dp_o(dp1), .ovf_led_o(led1));

  typedef struct packed {
    logic [7:0] ans;
    logic [6:0] seg;
    logic       dp;
    logic       led;
  } exp_t;

  exp_t q0[$], q1[$];
  int   tests = 0, fails = 0;

  logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: displayed value, overflow, and edges since reset.
  logic [31:0] m_val = '0;
  bit          m_ovf = 1'b0;
  int          m_n   = 0;

  function automatic exp_t model(input bit blz);
    exp_t        e;
    int          idx = (m_n / SD) % 8;
    logic [31:0] sh  = m_val >> (4 * idx);
    bit          blank = blz && (idx != 0) && (sh == 0);
    e.ans = 8'hFF;
    if (!blank) e.ans[idx] = 1'b0;
    e.seg = blank ? 7'h7F : HEX[sh[3:0]];
    e.dp  = !(idx == 0 && m_ovf);
    e.led = m_ovf;
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t r;
    if (rst) begin
      r = '{ans: 8'hFF, seg: 7'h7F, dp: 1'b1, led: 1'b0};
      q0.push_back(r);
      q1.push_back(r);
      m_val = '0;
      m_ovf = 1'b0;
      m_n   = 0;
    end else begin
      q0.push_back(model(1'b1));
      q1.push_back(model(1'b0));
      if (load) begin
        m_val = y;
        m_ovf = ovf;
      end
      m_n++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      tests++;
      if ({ans0, seg0, dp0, led0} !== e) begin
        fails++;
        $display("FAIL blz1 t=%0t got ans=%h seg=%h dp=%b led=%b want ans=%h seg=%h dp=%b led=%b",
                 $time, ans0, seg0, dp0, led0, e.ans, e.seg, e.dp, e.led);
      end
      tests++;
      if ($countones(~ans0) > 1) begin
        fails++;
        $display("FAIL onehot t=%0t got ans=%h want at most one low bit", $time, ans0);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      tests++;
      if ({ans1, seg1, dp1, led1} !== e) begin
        fails++;
        $display("FAIL blz0 t=%0t got ans=%h seg=%h dp=%b led=%b want ans=%h seg=%h dp=%b led=%b",
                 $time, ans1, seg1, dp1, led1, e.ans, e.seg, e.dp, e.led);
      end
    end
  end

  task automatic do_load(input logic [31:0] v, input logic o);
    load = 1'b1; y = v; ovf = o;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    do_load(32'h0000_1234, 1'b0); repeat (40) @(negedge clk);
    do_load(32'hDEAD_BEEF, 1'b0); repeat (40) @(negedge clk);
    do_load(32'h0000_0005, 1'b0); repeat (40) @(negedge clk);
    do_load(32'h0000_0000, 1'b0); repeat (40) @(negedge clk);
    do_load(32'h8000_0000, 1'b1); repeat (40) @(negedge clk);

    // Load y=2 exactly on the edge where idx wraps 7->0.
    do_load(32'h0000_0001, 1'b0);
    for (int k = 0; k < 64 && (m_n % (8 * SD)) != (8 * SD - 1); k++) @(negedge clk);
    tests++;
    if ((m_n % (8 * SD)) != (8 * SD - 1)) begin
      fails++;
      $display("FAIL tick_align got phase=%0d want %0d", m_n % (8 * SD), 8 * SD - 1);
    end
    do_load(32'h0000_0002, 1'b0); repeat (40) @(negedge clk);

    // Reset while digit 5 is being scanned, with load asserted.
    do_load(32'h7654_3210, 1'b1);
    for (int k = 0; k < 64 && ((m_n / SD) % 8) != 5; k++) @(negedge clk);
    tests++;
    if (((m_n / SD) % 8) != 5) begin
      fails++;
      $display("FAIL idx5_align got idx=%0d want 5", (m_n / SD) % 8);
    end
    rst = 1'b1; load = 1'b1; y = 32'hFFFF_FFFF; ovf = 1'b1;
    @(negedge clk);
    rst = 1'b0; load = 1'b0; ovf = 1'b0;
    repeat (40) @(negedge clk);

    // Held load and random traffic.
    load = 1'b1;
    for (int k = 0; k < 20; k++) begin y = $urandom; ovf = 1'(k % 2); @(negedge clk); end
    for (int k = 0; k < 3000; k++) begin
      rst  = ($urandom_range(0, 199) == 0);
      load = ($urandom_range(0, 3) == 0);
      y    = $urandom >> $urandom_range(0, 31);
      ovf  = 1'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; load = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
